sales_tally: RTL

SALES_TALLY -- requirements
Module: sales_tally

---
 rtl/sales_tally.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sales_tally.sv
// rtl/sales_tally.sv - per-channel sale counters and revenue total with show/clear FSM
// Define SALES_TALLY_SAT_EN to saturate tallies at all-ones instead of wrapping.
module sales_tally #(
    parameter int NCH     = 4,
    parameter int PRICE_W = 8,
    parameter int TOTAL_W = 16,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sale_vld,
    input  logic [$clog2(NCH)-1:0] sale_ch,
    input  logic [PRICE_W-1:0]     sale_price,
    input  logic                   total,
    input  logic                   clr_req,
    input  logic [$clog2(NCH)-1:0] sel_ch,
    output logic                   total_out,
    output logic [TOTAL_W-1:0]     total_amt,
    output logic [CNT_W-1:0]       ch_cnt,
    output logic                   busy,
    output logic                   ovf,
    output logic                   drop
);
    localparam int CH_W  = $clog2(NCH);
    localparam int SUM_W = ((PRICE_W > TOTAL_W) ? PRICE_W : TOTAL_W) + 1;
    localparam logic [CH_W:0]   NCH_V   = (CH_W + 1)'(NCH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    typedef enum logic [1:0] {IDLE, SHOW, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    clr_idx_q, clr_idx_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [CNT_W-1:0]   cnt_q [NCH];
    logic [CNT_W-1:0]   cnt_d [NCH];
    logic [CNT_W-1:0]   ch_cnt_q, ch_cnt_d;
    logic               ovf_q, ovf_d;
    logic               drop_q, drop_d;
    logic               total_out_q, busy_q;

    logic               clr_take, ch_ok, sale_take;
    logic [SUM_W-1:0]   sum;
    logic [CNT_W:0]     cnt_inc;

    always_comb begin
        clr_take  = clr_req && (state_q != CLEAR);
        ch_ok     = {1'b0, sale_ch} < NCH_V;
        sale_take = sale_vld && ch_ok && !clr_take && (state_q != CLEAR);
        sum       = SUM_W'(total_q) + SUM_W'(sale_price);
        cnt_inc   = {1'b0, cnt_q[sale_ch]} + 1'b1;

        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        total_d   = total_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        drop_d    = sale_vld && !sale_take;
        ch_cnt_d  = ({1'b0, sel_ch} < NCH_V) ? cnt_q[sel_ch] : '0;

        case (state_q)
            CLEAR: begin
                cnt_d[clr_idx_q] = '0;
                clr_idx_d        = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_CH) begin
                    state_d   = IDLE;
                    clr_idx_d = '0;
                end
            end
            default: begin
                if (clr_take) begin
                    // total and ovf are zeroed on entry so the whole sweep reads clean.
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                    total_d   = '0;
                    ovf_d     = 1'b0;
                end else begin
                    if (state_q == IDLE && total) begin
                        state_d = SHOW;
                    end else if (state_q == SHOW && !total) begin
                        state_d = IDLE;
                    end
                    if (sale_take) begin
                        total_d = sum[TOTAL_W-1:0];
                        if (sum[SUM_W-1:TOTAL_W] != '0) begin
                            ovf_d = 1'b1;
`ifdef SALES_TALLY_SAT_EN
                            total_d = '1;
`endif
                        end
                        cnt_d[sale_ch] = cnt_inc[CNT_W-1:0];
                        if (cnt_inc[CNT_W]) begin
                            ovf_d = 1'b1;
`ifdef SALES_TALLY_SAT_EN
                            cnt_d[sale_ch] = '1;
`endif
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            clr_idx_q   <= '0;
            total_q     <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
            ch_cnt_q    <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
            total_out_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            total_q     <= total_d;
            cnt_q       <= cnt_d;
            ch_cnt_q    <= ch_cnt_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            total_out_q <= (state_d == SHOW);
            busy_q      <= (state_d == CLEAR);
        end
    end

    assign total_out = total_out_q;
    assign total_amt = total_q;
    assign ch_cnt    = ch_cnt_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;
    assign drop      = drop_q;
endmodule
